// File: rtl/serial_echo_pkg.sv
// Shared constants for the serial echo engine: transform modes, output FSM encoding,
// and the statistics counter width.
package serial_echo_pkg;

    localparam int MODE_PASS = 0;
    localparam int MODE_ADD  = 1;
    localparam int MODE_XOR  = 2;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/echo_fifo.sv
// Synchronous FIFO with registered read port and fill-level output.
// The caller qualifies push (not full) and pop (not empty).
module echo_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop)  rd_data     <= mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/serial_echo_core.sv
// UART echo engine: buffers rx words, transforms them and presents them to the tx side
// with RTS/CTS flow control. Statistics counters exist only with SERIAL_ECHO_STATS_EN.
module serial_echo_core
    import serial_echo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int MODE       = MODE_ADD,
    parameter  int OPERAND    = 1,
    parameter  int RTS_HIGH   = FIFO_DEPTH - 4,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_err,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic                  cts_in,
    output logic                  rts_out,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow,
    input  logic                  clear_flags,
    output logic [CNT_W-1:0]      rx_count,
    output logic [CNT_W-1:0]      tx_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam logic [LW-1:0] FULL_LVL    = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] RTS_OFF_LVL = LW'(RTS_HIGH);
    localparam logic [LW-1:0] RTS_ON_LVL  = LW'(RTS_HIGH - 2);

    state_t                state;
    state_t                state_next;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  can_fetch;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [DATA_WIDTH-1:0] transform(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] k;
        k = DATA_WIDTH'(OPERAND);
        case (MODE)
            MODE_ADD: transform = d + k;
            MODE_XOR: transform = d ^ k;
            default:  transform = d;
        endcase
    endfunction

    assign full      = (fifo_level == FULL_LVL);
    assign push      = rx_valid & ~rx_err & ~full;
    assign can_fetch = (fifo_level != '0) & cts_in;
    assign tx_valid  = (state == ST_PRESENT);

    echo_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (rx_data),
        .pop     (pop),
        .rd_data (rd_data),
        .level   (fifo_level)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (can_fetch) begin
                    pop        = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                load       = 1'b1;
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                // Once presented, the word stays put until accepted regardless of cts_in.
                if (tx_ready) begin
                    if (can_fetch) begin
                        pop        = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_next;
            if (load) tx_data <= transform(rd_data);
        end
    end

    // RTS hysteresis: drop at RTS_HIGH, re-assert only once two below it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rts_out  <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (fifo_level >= RTS_OFF_LVL)     rts_out <= 1'b0;
            else if (fifo_level <= RTS_ON_LVL) rts_out <= 1'b1;
            if (clear_flags)                       overflow <= 1'b0;
            else if (rx_valid & ~rx_err & full)    overflow <= 1'b1;
        end
    end

`ifdef SERIAL_ECHO_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == '1) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_count  <= '0;
            tx_count  <= '0;
            err_count <= '0;
        end else if (clear_flags) begin
            rx_count  <= '0;
            tx_count  <= '0;
            err_count <= '0;
        end else begin
            if (push)                rx_count  <= sat_inc(rx_count);
            if (tx_valid & tx_ready) tx_count  <= sat_inc(tx_count);
            if (rx_valid & rx_err)   err_count <= sat_inc(err_count);
        end
    end
`else
    assign rx_count  = '0;
    assign tx_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_echo_core.sv
// Scoreboard bench for serial_echo_core: three instances (add/xor/pass) share stimulus;
// a negedge monitor checks every tx handshake against queued reference words.
module tb_serial_echo_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_err, tx_ready, cts_in, clear_flags;

    logic [7:0]  tx_data, tx_data_x, tx_data_p;
    logic        tx_valid, tx_valid_x, tx_valid_p;
    logic        rts_out, rts_x, rts_p;
    logic        overflow, ovf_x, ovf_p;
    logic [4:0]  fifo_level, lvl_x, lvl_p;
    logic [15:0] rx_count, tx_count, err_count;
    logic [15:0] rxc_x, txc_x, errc_x, rxc_p, txc_p, errc_p;

    int checks = 0;
    int errors = 0;
    int exp_rx = 0;
    int exp_tx = 0;
    int exp_err = 0;
    int sb[$];

    serial_echo_core dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .cts_in(cts_in),
        .rts_out(rts_out), .fifo_level(fifo_level), .overflow(overflow),
        .clear_flags(clear_flags), .rx_count(rx_count), .tx_count(tx_count),
        .err_count(err_count)
    );

    serial_echo_core #(.MODE(2), .OPERAND(8'h0F)) dut_x (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data_x), .tx_valid(tx_valid_x), .tx_ready(tx_ready), .cts_in(cts_in),
        .rts_out(rts_x), .fifo_level(lvl_x), .overflow(ovf_x),
        .clear_flags(clear_flags), .rx_count(rxc_x), .tx_count(txc_x),
        .err_count(errc_x)
    );

    serial_echo_core #(.MODE(0)) dut_p (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready), .cts_in(cts_in),
        .rts_out(rts_p), .fifo_level(lvl_p), .overflow(ovf_p),
        .clear_flags(clear_flags), .rx_count(rxc_p), .tx_count(txc_p),
        .err_count(errc_p)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int stat(input int v);
`ifdef SERIAL_ECHO_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Reference transforms from the mode definitions.
    function automatic int ref_add(input int w);
        return (w + 1) % 256;
    endfunction

    function automatic int ref_xor(input int w);
        return w ^ 'h0F;
    endfunction

    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_tx", 1, 0);
            end else begin
                int w;
                w = sb.pop_front();
                check("tx_add", int'(tx_data), ref_add(w));
                check("tx_xor", int'(tx_data_x), ref_xor(w));
                check("tx_pass", int'(tx_data_p), w);
                check("tx_valid_x", int'(tx_valid_x & tx_valid_p), 1);
                exp_tx++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_err   = e;
        tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        sb.push_back(int'(d));
        exp_rx++;
        send(d, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 20; k++) begin
            if (tx_valid) break;
            tick();
        end
        check(name, int'(tx_valid), 1);
    endtask

    task automatic pulse_ready();
        wait_valid("pulse_wait_valid");
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int done;
        done = 0;
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0 && !tx_valid && fifo_level == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        check(name, done, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_valid"}, int'(tx_valid), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_rts"}, int'(rts_out), 1);
        check({tag, "_level"}, int'(fifo_level), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_rx_count"}, int'(rx_count), 0);
        check({tag, "_tx_count"}, int'(tx_count), 0);
        check({tag, "_err_count"}, int'(err_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n, first, last, hs;
        logic [7:0] d;
        logic e;

        rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0;
        tx_ready = 1'b1; cts_in = 1'b1; clear_flags = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b1;
        tick();

        // Latency and ADD wrap.
        push_word(8'h41);
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            k++;
            if (tx_valid) break;
        end
        check("latency", k, 3);
        tick();
        push_word(8'hFF);
        push_word(8'hA5);
        push_word(8'h00);
        wait_idle("drain_basic");

        // CTS blocks fetches; then back-to-back throughput.
        cts_in = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'($urandom_range(0, 255)));
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (tx_valid) n++;
        end
        check("cts_block_valid", n, 0);
        check("cts_block_level", int'(fifo_level), 6);
        tick();
        cts_in = 1'b1;
        first = -1; last = -1; hs = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                hs++;
            end
            if (hs == 6) break;
        end
        check("throughput_span", last - first, 10);
        tick();
        wait_idle("drain_throughput");

        // cts_in falling while presenting does not withdraw the word.
        tx_ready = 1'b0;
        push_word(8'h30);
        wait_valid("present_wait");
        cts_in = 1'b0;
        repeat (4) tick();
        check("hold_valid", int'(tx_valid), 1);
        check("hold_data", int'(tx_data), ref_add(8'h30));
        tx_ready = 1'b1;
        tick();
        cts_in = 1'b1;
        wait_idle("drain_hold");

        // Fill, RTS hysteresis, overflow, ordered drain.
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        exp_rx = 0; exp_tx = 0; exp_err = 0;
        tx_ready = 1'b0;
        cts_in = 1'b0;
        for (int i = 0; i < 11; i++) push_word(8'($urandom_range(0, 255)));
        tick();
        check("rts_at_11", int'(rts_out), 1);
        check("level_11", int'(fifo_level), 11);
        push_word(8'($urandom_range(0, 255)));
        check("level_12", int'(fifo_level), 12);
        check("rts_lag", int'(rts_out), 1);
        tick();
        check("rts_fall", int'(rts_out), 0);
        for (int i = 0; i < 4; i++) push_word(8'($urandom_range(0, 255)));
        send(8'h5A, 1'b0);
        check("level_full", int'(fifo_level), 16);
        check("overflow_set", int'(overflow), 1);
        cts_in = 1'b1;
        repeat (3) tick();
        check("level_after_fetch", int'(fifo_level), 15);
        repeat (4) pulse_ready();
        tick();
        tick();
        check("level_hold_11", int'(fifo_level), 11);
        check("rts_hold_11", int'(rts_out), 0);
        pulse_ready();
        tick();
        check("level_10", int'(fifo_level), 10);
        check("rts_rise", int'(rts_out), 1);
        tx_ready = 1'b1;
        wait_idle("drain_full");
        check("rx_count_full", int'(rx_count), stat(exp_rx));
        check("tx_count_full", int'(tx_count), stat(exp_tx));
        check("overflow_sticky", int'(overflow), 1);

        // Clear coinciding with a push: word kept, not counted.
        rx_data = 8'h10; rx_valid = 1'b1; clear_flags = 1'b1;
        sb.push_back(8'h10);
        tick();
        rx_valid = 1'b0; clear_flags = 1'b0;
        exp_rx = 0; exp_tx = 0; exp_err = 0;
        check("clear_overflow", int'(overflow), 0);
        check("clear_rx_count", int'(rx_count), 0);
        wait_idle("drain_clear");
        check("tx_count_after_clear", int'(tx_count), stat(exp_tx));

        // Errored word is discarded and counted.
        send(8'h55, 1'b1);
        exp_err++;
        tick();
        check("err_level", int'(fifo_level), 0);
        check("err_no_valid", int'(tx_valid), 0);
        check("err_count", int'(err_count), stat(exp_err));

        // Randomised traffic with random back-pressure and CTS.
        for (int i = 0; i < 400; i++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            cts_in   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1 && fifo_level < 13) begin
                d = 8'($urandom_range(0, 255));
                e = ($urandom_range(0, 7) == 0);
                rx_data = d; rx_valid = 1'b1; rx_err = e;
                if (e) exp_err++;
                else begin
                    sb.push_back(int'(d));
                    exp_rx++;
                end
            end else begin
                rx_valid = 1'b0; rx_err = 1'b0;
            end
            tick();
        end
        rx_valid = 1'b0; rx_err = 1'b0; cts_in = 1'b1; tx_ready = 1'b1;
        wait_idle("drain_random");
        check("rand_rx_count", int'(rx_count), stat(exp_rx));
        check("rand_tx_count", int'(tx_count), stat(exp_tx));
        check("rand_err_count", int'(err_count), stat(exp_err));
        check("rand_overflow", int'(overflow), 0);

        // Asynchronous reset mid-stream discards everything.
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(8'($urandom_range(0, 255)));
        wait_valid("pre_reset_valid");
        #1 rst = 1'b0;
        #1 check_reset_vals("midrst");
        sb.delete();
        exp_rx = 0; exp_tx = 0; exp_err = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        tx_ready = 1'b1;
        repeat (10) tick();
        check("post_reset_level", int'(fifo_level), 0);
        check("post_reset_valid", int'(tx_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_echo_core.md
# serial_echo_core

Parametrised byte-stream echo engine sitting between a UART receiver and UART transmitter of the QuickRS232 family. Received words are buffered in an internal FIFO, transformed (pass, add constant, or XOR constant) and presented to the transmitter under a valid/ready handshake. RTS/CTS hardware flow control with hysteresis throttles the remote peer and the local transmitter. Generalises the fixed 8-bit "+1" echo to configurable width, depth, operation and flow control.

## Interface
- DATA_WIDTH, 8, word width (5..9).
- FIFO_DEPTH, 16, buffer depth; power of two, >= 4.
- MODE, 1, transform: 0 pass, 1 add OPERAND, 2 xor OPERAND; other values behave as 0.
- OPERAND, 1, transform constant, truncated to DATA_WIDTH.
- RTS_HIGH, FIFO_DEPTH-4, fill level at/above which rts_out drops; must be >= 3.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_data  in  DATA_WIDTH  received word, qualified by rx_valid.
- rx_valid  in  1  single-cycle strobe, one per received word.
- rx_err  in  1  parity/framing error for the current rx_valid word.
- tx_data  out  DATA_WIDTH  transformed word to transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- cts_in  in  1  peer clear-to-send; low blocks new fetches.
- rts_out  out  1  local request-to-send; high = peer may send.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current fill.
- overflow  out  1  sticky: word dropped on full FIFO.
- clear_flags  in  1  pulse; clears overflow and counters.
- rx_count, tx_count, err_count  out  16 each  statistics (see Configuration).

## Operation
- Write: rx_valid & !rx_err & level<FIFO_DEPTH -> word pushed. rx_valid & rx_err -> word discarded, err_count++. rx_valid on full -> word discarded, overflow set; a same-cycle pop does not rescue it.
- Output FSM, states IDLE, FETCH, PRESENT:
  - IDLE: level>0 & cts_in -> pop (registered read) -> FETCH.
  - FETCH: transform applied to read data, registered into tx_data -> PRESENT.
  - PRESENT: tx_valid=1; on tx_valid&tx_ready: if level>0 & cts_in pop -> FETCH, else -> IDLE. cts_in falling while in PRESENT does not withdraw tx_valid or change tx_data.
- Transform: ADD modulo 2^DATA_WIDTH (0xFF+1 -> 0x00 at 8 bits); XOR bitwise with OPERAND.
- rts_out: registered; falls when level >= RTS_HIGH; rises when level <= RTS_HIGH-2; holds otherwise.
- clear_flags: clears overflow and all counters next edge; same-cycle event is not counted and does not set overflow.
- Simultaneous push and pop: level unchanged, both take effect.

## Timing
- Reset values: tx_data 0, tx_valid 0, rts_out 1, fifo_level 0, overflow 0, counters 0, FSM IDLE, FIFO pointers 0.
- Latency: rx_valid at cycle N into empty FIFO, FSM IDLE, cts_in high -> tx_valid high at N+3.
- Throughput: one word per 2 cycles with tx_ready held high.
- rts_out updates one cycle after the level crossing.
- rst asserted mid-operation: FIFO contents and presented word lost; all outputs to reset values asynchronously.

## Configuration
- SERIAL_ECHO_STATS_EN defined: rx_count counts accepted pushes, tx_count completed tx handshakes, err_count rx_err strobes; all saturate at 0xFFFF.
- Undefined: the three counter ports remain, tied to 0; no counter logic synthesised. All other behaviour identical.

## Structure
- serial_echo_pkg: MODE constants (MODE_PASS, MODE_ADD, MODE_XOR), FSM state encoding, counter width constant.
- One sub-module: echo_fifo (synchronous FIFO, registered read, level output, DEPTH/WIDTH parameters).

## Test plan
- Defaults, push 0x41 -> tx_valid at +3 cycles, tx_data 0x42; push 0xFF -> 0x00.
- MODE=2, OPERAND=0x0F, push 0xA5 -> 0xAA; MODE=0 -> 0xA5 unchanged.
- tx_ready low, push 12 words -> rts_out falls when level reaches 12; drain to 10 -> rts_out rises.
- tx_ready low, push 17 words -> level 16, overflow=1, 17th lost; drain -> first 16 words in order, each +1.
- cts_in low with 3 words queued -> no tx_valid; cts_in high -> 3 words emitted; cts_in dropped during PRESENT -> tx_valid held until tx_ready.
- rx_err with rx_valid -> no push, err_count=1 (STATS_EN) or 0; rst mid-stream -> all outputs reset values.
